// File: rtl/key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : key_loader
//  Description : Byte-serial AES key collector. Assembles up to 32 key bytes
//                into a left-justified key and flags it ready once complete.
//                Optional macro KEY_LOADER_KEYLEN_EN adds 128/192/256-bit
//                key length selection through the key_len port.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_loader #(
    parameter int KEY_BYTES = 32,
    parameter int CNT_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             din,
    input  logic                   valid,
`ifdef KEY_LOADER_KEYLEN_EN
    input  logic [1:0]             key_len,
`endif
    output logic [8*KEY_BYTES-1:0] key_out,
    output logic                   ready
);

    localparam int               c_key_w   = 8 * KEY_BYTES;
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(KEY_BYTES - 1);

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_load = 2'd1;
    localparam logic [1:0]       c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_key_w-1:0] r_sr;
    logic [c_key_w-1:0] r_key;
    logic [c_key_w-1:0] w_full;
    logic [c_key_w-1:0] w_key_nxt;
    logic               w_is_last;

    assign w_full = {r_sr[c_key_w-9:0], din};

`ifdef KEY_LOADER_KEYLEN_EN
    logic [1:0] r_len;
    logic [1:0] w_len;

    // The length is captured with the first byte; later changes to key_len
    // must not affect a key already in flight.
    assign w_len = (r_cnt == '0) ? key_len : r_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= 2'b10;
        end else if (valid && (r_cnt == '0)) begin
            r_len <= key_len;
        end
    end

    // Shorter keys sit in the low bytes of the shift register; shifting left
    // drops stale bytes from earlier keys and leaves zeros in the low bits.
    always_comb begin
        w_is_last = 1'b0;
        w_key_nxt = w_full;
        case (w_len)
            2'b00: begin
                w_is_last = (r_cnt == CNT_W'(15));
                w_key_nxt = w_full << 128;
            end
            2'b01: begin
                w_is_last = (r_cnt == CNT_W'(23));
                w_key_nxt = w_full << 64;
            end
            default: begin
                w_is_last = (r_cnt == c_last);
                w_key_nxt = w_full;
            end
        endcase
    end
`else
    assign w_is_last = (r_cnt == c_last);
    assign w_key_nxt = w_full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_key <= '0;
        end else if (valid) begin
            r_sr <= w_full;
            if (w_is_last) begin
                r_cnt <= '0;
                r_key <= w_key_nxt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every state reacts identically to a valid byte; only the last byte of
    // a key decides between LOADING and DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle,
            c_st_load,
            c_st_done: begin
                if (valid) begin
                    w_state_nxt = w_is_last ? c_st_done : c_st_load;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign key_out = r_key;
    assign ready   = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_loader
//  Description : Scoreboard bench for key_loader with directed key vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_loader;

    logic         clk;
    logic         rst;
    logic [7:0]   din;
    logic         valid;
    logic [255:0] key_out;
    logic         ready;
`ifdef KEY_LOADER_KEYLEN_EN
    logic [1:0]   key_len;
`endif

    key_loader #(
        .KEY_BYTES (32),
        .CNT_W     (6)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .valid   (valid),
`ifdef KEY_LOADER_KEYLEN_EN
        .key_len (key_len),
`endif
        .key_out (key_out),
        .ready   (ready)
    );

    typedef struct {
        logic [255:0] key;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;

    localparam logic [255:0] c_key_inc  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] c_key_dec  = 256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0;
    localparam logic [255:0] c_key_gap  = 256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;
    localparam logic [255:0] c_key_aa   = {32{8'haa}};
    localparam logic [255:0] c_key_k128 = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        din   = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends n bytes start, start+step, ...; queues exp for the final byte if push.
    task automatic send_seq(input logic [7:0] start, input int step, input int n,
                            input int gap, input logic [255:0] exp, input bit push);
        logic [7:0] b;
        exp_t       e;
        for (int i = 0; i < n; i++) begin
            b = start + 8'(i * step);
            if (push && (i == n - 1)) begin
                e.key = exp;
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            drive(b);
            if (gap > 0) idle(gap);
        end
    endtask

    // Monitor: every rising edge of ready must match the next queued key.
    initial begin
        logic prev_ready;
        exp_t e;
        prev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready === 1'b1 && prev_ready !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 256'(ready), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_key", key_out, e.key);
                    check("sb_latency_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
            prev_ready = ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid    = 1'b0;
        din      = 8'h00;
`ifdef KEY_LOADER_KEYLEN_EN
        key_len  = 2'b10;
`endif
        idle(2);
        check("reset_key", key_out, 256'h0);
        check("reset_ready", 256'(ready), 256'(0));
        rst = 1'b0;
        idle(1);
        check("post_reset_ready", 256'(ready), 256'(0));

        // Spaced bytes 00..1f, then hold for 5 idle cycles.
        send_seq(8'h00, 1, 32, 1, c_key_inc, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_ready", 256'(ready), 256'(1));
            check("hold_key", key_out, c_key_inc);
            idle(1);
        end

        // Back-to-back ff..e0.
        send_seq(8'hff, -1, 32, 0, c_key_dec, 1'b1);
        check("b2b_key", key_out, c_key_dec);

        // New key drops ready but keeps the old key visible.
        drive(8'h11);
        check("newkey_ready_drop", 256'(ready), 256'(0));
        check("newkey_old_key", key_out, c_key_dec);
        send_seq(8'h12, 1, 9, 0, 256'h0, 1'b0);
        check("partial_old_key", key_out, c_key_dec);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_partial_key", key_out, 256'h0);
        check("rst_partial_ready", 256'(ready), 256'(0));
        send_seq(8'haa, 0, 32, 0, c_key_aa, 1'b1);
        check("aa_key", key_out, c_key_aa);

        // 31 bytes with a long gap, then the final byte.
        send_seq(8'h40, 1, 15, 0, 256'h0, 1'b0);
        idle(20);
        send_seq(8'h4f, 1, 16, 0, 256'h0, 1'b0);
        check("gap_31_ready", 256'(ready), 256'(0));
        check("gap_31_key", key_out, c_key_aa);
        send_seq(8'h5f, 1, 1, 0, c_key_gap, 1'b1);
        check("gap_key", key_out, c_key_gap);

`ifdef KEY_LOADER_KEYLEN_EN
        // 128-bit key; key_len changes mid-key must be ignored.
        key_len = 2'b00;
        send_seq(8'h00, 1, 4, 0, 256'h0, 1'b0);
        key_len = 2'b10;
        send_seq(8'h04, 1, 12, 0, c_key_k128, 1'b1);
        check("k128_key", key_out, c_key_k128);
        check("k128_ready", 256'(ready), 256'(1));
`endif

        idle(3);
        check("pending_keys", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_loader.md
Name: key_loader

Overview:
- Byte-serial key collector for the AES core.
- Accepts one key byte per clock on a valid strobe and assembles a 256-bit key.
- Presents the completed key, with a ready flag, to the key-expansion logic.
- key_out changes only when a full key has been received; it never exposes a partially loaded key.

Parameters:
- KEY_BYTES, 32, number of bytes per key at full length. Fixed at 32 for AES-256; key_out width = 8*KEY_BYTES.
- CNT_W, 6, width of the internal byte counter. Must hold 0..KEY_BYTES.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, synchronous, active-high; sampled on rising clk.
- din  input  8  key byte.
- valid  input  1  din is valid this cycle; one byte is consumed per rising edge where valid=1.
- key_out  output  256  completed key, first-received byte in [255:248], last in [7:0].
- ready  output  1  high when key_out holds a complete, stable key.

Behaviour:
- Reset (rst=1 at a rising edge): key_out=0, ready=0, byte counter=0, shift register=0. Reset overrides valid in the same cycle.
- Loading:
  - Each edge with valid=1 shifts din into the internal shift register: sr <= {sr[247:0], din}.
  - The counter increments on the same edge.
  - valid=0 edges hold all state; gaps of any length between bytes are allowed.
- Completion:
  - On the edge accepting the final byte (counter == KEY_BYTES-1), key_out <= {sr[247:0], din} and ready <= 1.
  - The counter returns to 0 on that edge.
  - Latency: key_out and ready are valid one cycle after the last byte is presented.
- Hold: ready and key_out hold indefinitely while valid=0.
- New key after ready:
  - The first valid byte after completion drops ready to 0 on that edge and starts a new key.
  - key_out keeps the old key until the new key completes.
- Byte order: bytes 00,01,...,1f in sequence yield key_out = 0x000102...1e1f.
- Partial load followed by rst: all progress is discarded and ready=0.
- There is no backpressure; every valid byte is accepted.
- Internal states:
  - IDLE: counter=0, ready=0.
  - LOADING: 0 < counter < KEY_BYTES.
  - DONE: ready=1.
  - Transitions: IDLE→LOADING on the first valid; LOADING→DONE on the last byte; DONE→LOADING on the next valid; any state→IDLE on rst.
  - Exception: with KEY_BYTES=1, IDLE→DONE directly.

Optional Feature:
- Macro KEY_LOADER_KEYLEN_EN.
- When defined:
  - Adds input port key_len [1:0]: 00=128-bit (16 bytes), 01=192-bit (24 bytes), 10 or 11=256-bit (32 bytes).
  - key_len is sampled on the first byte of each key and held for that key; changes mid-key are ignored.
  - Completion occurs after the selected byte count.
  - key_out is left-justified: first byte in [255:248]; unused low bits are zero (128-bit key in [255:128], [127:0]=0).
- When undefined: no key_len port; always 32 bytes.

Test Plan:
- Apply rst=1 for 2 cycles, then release → key_out=0, ready=0.
- Send bytes 0x00..0x1f with valid pulsed one cycle, each followed by one idle cycle → after the last byte, ready=1 and key_out=0x000102...1f; both remain stable for 5 idle cycles.
- Send 32 back-to-back bytes 0xff..0xe0 (valid continuously high) → ready rises exactly one cycle after the 32nd byte; key_out=0xfffefd...e0.
- After a completed key, send 10 bytes of a new key → ready drops on the first new byte, and key_out retains the old key. Assert rst, then load 32 bytes of 0xaa → key_out=all 0xaa; none of the 10 partial bytes appear.
- Send 31 bytes, with valid held low for 20 cycles between bytes 15 and 16 → ready stays 0. Send the 32nd byte → ready=1 with the correct key.
- With KEY_LOADER_KEYLEN_EN and key_len=00, send 0x00..0x0f → ready=1 after the 16th byte; key_out = 0x000102...0f followed by 128 zero bits.
